// File: rtl/banco_pkg.sv
// Shared constants for the register bank: default widths, reset base value
// and the architectural register indices that get special treatment.
package banco_pkg;

  localparam int          BANCO_DATA_W    = 32;
  localparam int          BANCO_ADDR_W    = 5;
  localparam logic [31:0] BANCO_DATA_BASE = 32'h1000_0000;

  localparam int ZERO = 0;
  localparam int T3   = 11;
  localparam int T4   = 12;

endpackage

// File: rtl/banco_scoreboard.sv
// Busy scoreboard: one bit per register, set by reservations, cleared by
// writes (reservation wins), with a registered popcount.
module banco_scoreboard
  import banco_pkg::*;
#(
  parameter int ADDR_W = BANCO_ADDR_W,
  parameter int NRD    = 4,
  parameter int NWR    = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NWR-1:0]        rsv_flag,
  input  logic [NWR*ADDR_W-1:0] rsv_reg,
  input  logic [NWR-1:0]        wr_flag,
  input  logic [NWR*ADDR_W-1:0] wr_reg,
  input  logic [NRD*ADDR_W-1:0] rd_addr,
  output logic [NRD-1:0]        rd_busy,
  output logic [ADDR_W:0]       num_busy
);

  localparam int NREG = 2 ** ADDR_W;

  logic [NREG-1:0] busy_q, busy_d;
  logic [NREG-1:0] set_v, clr_v;
  logic [ADDR_W:0] num_busy_q, num_busy_d;
  logic [ADDR_W-1:0] a;

  always_comb begin
    set_v = '0;
    clr_v = '0;
    for (int j = 0; j < NWR; j++) begin
      if (!rsv_flag[j]) set_v[rsv_reg[j*ADDR_W +: ADDR_W]] = 1'b1;
      if (!wr_flag[j])  clr_v[wr_reg[j*ADDR_W +: ADDR_W]]  = 1'b1;
    end
    set_v[ZERO] = 1'b0;
    clr_v[ZERO] = 1'b0;

    // a new producer outranks the one completing this cycle
    busy_d = (busy_q & ~clr_v) | set_v;

    num_busy_d = '0;
    for (int r = 0; r < NREG; r++) begin
      num_busy_d = num_busy_d + (ADDR_W+1)'(busy_d[r]);
    end

    rd_busy = '0;
    a       = '0;
    for (int i = 0; i < NRD; i++) begin
      a = rd_addr[i*ADDR_W +: ADDR_W];
      rd_busy[i] = set_v[a] ? busy_q[a] : (busy_q[a] & ~clr_v[a]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q     <= '0;
      num_busy_q <= '0;
    end else begin
      busy_q     <= busy_d;
      num_busy_q <= num_busy_d;
    end
  end

  assign num_busy = num_busy_q;

endmodule

// File: rtl/banco_registros_n.sv
// Multi-port register file with write-to-read bypass and a busy scoreboard.
// Write and reservation enables are active-low.
module banco_registros_n
  import banco_pkg::*;
#(
  parameter int                DATA_W    = BANCO_DATA_W,
  parameter int                ADDR_W    = BANCO_ADDR_W,
  parameter int                NRD       = 4,
  parameter int                NWR       = 2,
  parameter logic [DATA_W-1:0] DATA_BASE = DATA_W'(BANCO_DATA_BASE)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NRD*ADDR_W-1:0] rd_addr,
  output logic [NRD*DATA_W-1:0] rd_data,
  output logic [NRD-1:0]        rd_busy,
  input  logic [NWR-1:0]        write_reg_flag,
  input  logic [NWR*ADDR_W-1:0] write_reg,
  input  logic [NWR*DATA_W-1:0] write_data,
  input  logic [NWR-1:0]        rsv_flag,
  input  logic [NWR*ADDR_W-1:0] rsv_reg,
  output logic [ADDR_W:0]       num_busy
);

  localparam int NREG = 2 ** ADDR_W;

  logic [DATA_W-1:0] regs_q [NREG];
  logic [DATA_W-1:0] regs_d [NREG];
  logic [ADDR_W-1:0] ra;

  // ascending port order lets the highest-index writer win
  always_comb begin
    regs_d = regs_q;
    for (int j = 0; j < NWR; j++) begin
      if (!write_reg_flag[j])
        regs_d[write_reg[j*ADDR_W +: ADDR_W]] = write_data[j*DATA_W +: DATA_W];
    end
    regs_d[ZERO] = '0;
  end

  always_comb begin
    rd_data = '0;
    ra      = '0;
    for (int i = 0; i < NRD; i++) begin
      ra = rd_addr[i*ADDR_W +: ADDR_W];
      rd_data[i*DATA_W +: DATA_W] = regs_q[ra];
      for (int j = 0; j < NWR; j++) begin
        if (!write_reg_flag[j] && ra != '0 && write_reg[j*ADDR_W +: ADDR_W] == ra)
          rd_data[i*DATA_W +: DATA_W] = write_data[j*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < NREG; r++)
        regs_q[r] <= (r == T3 || r == T4) ? DATA_BASE : '0;
    end else begin
      regs_q <= regs_d;
    end
  end

  banco_scoreboard #(
    .ADDR_W (ADDR_W),
    .NRD    (NRD),
    .NWR    (NWR)
  ) u_scoreboard (
    .clk      (clk),
    .rst      (rst),
    .rsv_flag (rsv_flag),
    .rsv_reg  (rsv_reg),
    .wr_flag  (write_reg_flag),
    .wr_reg   (write_reg),
    .rd_addr  (rd_addr),
    .rd_busy  (rd_busy),
    .num_busy (num_busy)
  );

endmodule

// File: doc/banco_registros_n.md
BANCO_REGISTROS_N -- requirements
Module: banco_registros_n

Interface
REQ-001 Parameter DATA_W, default 32, register data width in bits.
REQ-002 Parameter ADDR_W, default 5, register address width; NREG = 2**ADDR_W registers.
REQ-003 Parameter NRD, default 4, number of read ports.
REQ-004 Parameter NWR, default 2, number of write ports; each write port also has one scoreboard reservation port.
REQ-005 Parameter DATA_BASE, default 32'h1000_0000, reset value of registers 11 and 12.
REQ-006 clk  input  1  single clock; all state updates on rising edge.
REQ-007 rst  input  1  reset, synchronous, active-high.
REQ-008 rd_addr  input  NRD*ADDR_W  read addresses, port i in bits [i*ADDR_W +: ADDR_W].
REQ-009 rd_data  output  NRD*DATA_W  read data, packed like rd_addr.
REQ-010 rd_busy  output  NRD  1 = register at rd_addr[i] has an outstanding producer.
REQ-011 write_reg_flag  input  NWR  write enable per port, active-low (0 = write).
REQ-012 write_reg  input  NWR*ADDR_W  write addresses.
REQ-013 write_data  input  NWR*DATA_W  write data.
REQ-014 rsv_flag  input  NWR  reservation enable per port, active-low (0 = mark destination busy).
REQ-015 rsv_reg  input  NWR*ADDR_W  reservation destination addresses.
REQ-016 num_busy  output  ADDR_W+1  count of registers currently marked busy.

Function
REQ-017 Register 0 reads 0, is never written, is never reserved, and never reports busy.
REQ-018 Writes take effect on the rising edge where write_reg_flag[j]=0.
REQ-019 Reads are combinational; with no write to that address in the current cycle, rd_data[i] = stored register value.
REQ-020 Write-to-read bypass: if any active write port targets rd_addr[i] (nonzero), rd_data[i] = that port's write_data in the same cycle.
REQ-021 Write conflict on the same address: the highest-index port wins, for both the stored value and the bypass value.
REQ-022 The busy bit for register r sets on the rising edge where any rsv_flag[j]=0 with rsv_reg[j]=r (r!=0).
REQ-023 The busy bit for register r clears on the rising edge where any active write targets r.
REQ-024 Reservation and write to the same register in the same cycle leave the bit set (the new producer wins).
REQ-025 rd_busy[i] = busy[rd_addr[i]] and not (active write to rd_addr[i] this cycle), unless a reservation to that address is also active this cycle, in which case the previous busy bit is shown.
REQ-026 Reserving an already-busy register keeps it busy; it is not counted twice.
REQ-027 Writing a non-busy register is legal; the value updates and busy stays 0.
REQ-028 num_busy is registered; it equals the popcount of the busy vector after each edge and never exceeds NREG-1.
REQ-029 There are no unassigned output cases; all outputs are fully defined for every input combination (no latches).

Reset
REQ-030 While rst=1 at a rising edge, all registers load 0 except registers 11 and 12, which load DATA_BASE.
REQ-031 While rst=1 at a rising edge, all busy bits clear and num_busy loads 0.
REQ-032 Reset has priority over simultaneous writes and reservations; rd_data stays combinational during reset.

Structure
REQ-033 DATA_W, ADDR_W, DATA_BASE defaults and the register index constants (ZERO=0, T3=11, T4=12) reside in the shared package banco_pkg.
REQ-034 The scoreboard (busy vector, set/clear priority, popcount) is one sub-module, banco_scoreboard; the storage and bypass stay in banco_registros_n.

Verification
REQ-035 Reset, then read ports 0..3 at addresses 0, 11, 12, 5 -> 0, 0x10000000, 0x10000000, 0.
REQ-036 Write port 0 to reg 8 = 0xDEADBEEF and read reg 8 in the same cycle -> rd_data = 0xDEADBEEF before the edge; the stored value persists after the edge.
REQ-037 Both write ports target reg 9 (port 0 = 0x1, port 1 = 0x2) -> bypass and stored value = 0x2.
REQ-038 Write 0x55 to reg 0 -> read of reg 0 stays 0; reserve reg 0 -> num_busy stays 0.
REQ-039 Reserve regs 4 and 5 -> next cycle rd_busy set for both, num_busy = 2; write reg 4 -> rd_busy[reg4] drops in the write cycle, num_busy = 1 after the edge.
REQ-040 Reserve and write reg 6 in the same cycle, then assert rst mid-sequence -> busy stays 1 after the first edge; after reset, all busy bits are 0 and reg 6 reads 0.
